intr_ctrl: RTL and testbench

//  Interrupt controller downstream of the timer: collects the timer intr pulse (src 0) plus
//  up to NR_SRC-1 peripheral lines, latches them as pending, masks and fixed-priority

---
 rtl/intc_pkg.sv | 13 +
 rtl/intc_prio_enc.sv | 17 +
 rtl/intr_ctrl.sv | 79 +++++++
 tb/tb_intr_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// intc_pkg: shared register map, source ids and id width for the interrupt controller
package intc_pkg;
    typedef enum logic [2:0] {
        INTC_PENDING = 3'd0,
        INTC_ENABLE  = 3'd1,
        INTC_EDGE    = 3'd2,
        INTC_CLAIM   = 3'd3,
        INTC_INSERV  = 3'd4
    } intc_addr_e;
    localparam int INTC_SRC_TIMER = 0;
    localparam int INTC_MAX_SRC   = 31;
    localparam int INTC_ID_W      = 5;
endpackage

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: combinational lowest-index-wins priority encoder
module intc_prio_enc
    import intc_pkg::*;
#(
    parameter int NR_SRC = 8
) (
    input  logic [NR_SRC-1:0]    req,
    output logic                 valid,
    output logic [INTC_ID_W-1:0] id
);
    // scan from the top down so the lowest set index is the last one kept
    always_comb begin
        id = '0;
        for (int i = NR_SRC - 1; i >= 0; i--) id = req[i] ? i[INTC_ID_W-1:0] : id;
    end
    assign valid = |req;
endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: pending/enable/edge registers, fixed-priority claim/complete, irq to CPU (optional INTC_SYNC_EN input synchroniser)
module intr_ctrl
    import intc_pkg::*;
#(
    parameter int          NR_SRC   = 8,
    parameter logic [31:0] EDGE_RST = 32'h1,
    parameter int          XLEN     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NR_SRC-1:0] src,
    output logic              irq,
    input  logic              bus_req,
    input  logic              bus_wen,
    input  logic [XLEN-1:0]   bus_addr,
    input  logic [1:0]        bus_mode,
    input  logic [XLEN-1:0]   bus_dat_i,
    output logic [XLEN-1:0]   bus_dat_o,
    output logic              bus_ready
);
    logic [NR_SRC-1:0]    src_s, src_q, pending, enable, edge_r, set, clr, w1c, cand_req;
    logic [INTC_ID_W-1:0] inserv, cand_id;
    logic                 cand_vld, rd, wr, claim, complete, unused;
    logic [2:0]           sel;
    logic [XLEN-1:0]      rd_dat;
`ifdef INTC_SYNC_EN
    logic [NR_SRC-1:1] sync1, sync2;
    // two-flop synchroniser for the asynchronous peripheral lines; the timer shares our clock
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= src[NR_SRC-1:1];
            sync2 <= sync1;
        end
    assign src_s = {sync2, src[INTC_SRC_TIMER]};
`else
    assign src_s = src;
`endif
    assign sel       = bus_addr[4:2];
    assign rd        = bus_req & ~bus_wen;
    assign wr        = bus_req & bus_wen;
    assign bus_ready = 1'b1;
    assign unused    = &{1'b0, bus_mode, bus_addr[XLEN-1:5], bus_addr[1:0]};
    // nothing competes for the CPU while a source is in service
    assign cand_req  = pending & enable & {NR_SRC{inserv == '0}};
    intc_prio_enc #(.NR_SRC(NR_SRC)) u_enc (.req(cand_req), .valid(cand_vld), .id(cand_id));
    assign claim    = rd & (sel == INTC_CLAIM) & cand_vld;
    assign complete = wr & (sel == INTC_CLAIM) & (bus_dat_i == XLEN'(inserv)) & (inserv != '0);
    // edge sources fire on a rising transition, level sources every cycle they are high
    assign set = src_s & ~(src_q & edge_r);
    assign w1c = (wr && sel == INTC_PENDING) ? bus_dat_i[NR_SRC-1:0] : '0;
    assign clr = w1c | (claim ? NR_SRC'(1'b1) << cand_id : '0);
    assign rd_dat = sel == INTC_PENDING ? XLEN'(pending) :
                    sel == INTC_ENABLE  ? XLEN'(enable)  :
                    sel == INTC_EDGE    ? XLEN'(edge_r)  :
                    sel == INTC_CLAIM   ? (cand_vld ? XLEN'(cand_id) + XLEN'(1) : '0) :
                    sel == INTC_INSERV  ? XLEN'(inserv)  : '0;
    // register state; a new event on a bit outranks a clear of that bit in the same cycle
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            src_q     <= '0;
            pending   <= '0;
            enable    <= '0;
            edge_r    <= EDGE_RST[NR_SRC-1:0];
            inserv    <= '0;
            irq       <= 1'b0;
            bus_dat_o <= '0;
        end else begin
            src_q     <= src_s;
            pending   <= (pending & ~clr) | set;
            enable    <= (wr && sel == INTC_ENABLE) ? bus_dat_i[NR_SRC-1:0] : enable;
            edge_r    <= (wr && sel == INTC_EDGE) ? bus_dat_i[NR_SRC-1:0] : edge_r;
            inserv    <= claim ? cand_id + 1'b1 : complete ? '0 : inserv;
            irq       <= cand_vld;
            bus_dat_o <= rd ? rd_dat : '0;
        end
endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: vector table, directed claim/complete sequences and random run against a behavioural model
module tb_intr_ctrl;
    localparam int NR = 8;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  src = '0;
    logic        irq;
    logic        bus_req = 1'b0, bus_wen = 1'b0;
    logic [31:0] bus_addr = '0, bus_dat_i = '0, bus_dat_o;
    logic [1:0]  bus_mode = 2'b10;
    logic        bus_ready;
    int tests = 0, fails = 0;
    bit [NR-1:0] m_pend, m_en, m_edge, m_prev;
    int          m_ins;
    bit          m_irq;
    logic [31:0] m_dat;
    typedef struct {
        logic [7:0]  s;
        bit          rq;
        bit          we;
        logic [2:0]  r;
        logic [31:0] d;
        bit          ei;
        logic [31:0] ed;
    } vec_t;
    vec_t vq[$];

    intr_ctrl #(.NR_SRC(NR), .EDGE_RST(32'h1), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .src(src), .irq(irq), .bus_req(bus_req), .bus_wen(bus_wen),
        .bus_addr(bus_addr), .bus_mode(bus_mode), .bus_dat_i(bus_dat_i), .bus_dat_o(bus_dat_o),
        .bus_ready(bus_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_en = '0; m_edge = 8'h01; m_prev = '0; m_ins = 0; m_irq = 0; m_dat = '0;
    endtask

    // one clock: drive inputs after a falling edge, advance the model, return at the next falling edge
    task automatic cyc(input logic [7:0] s, input bit rq, input bit we, input logic [2:0] r, input logic [31:0] d);
        int cand;
        bit [NR-1:0] n_pend, n_en, n_edge;
        int n_ins;
        logic [31:0] rv;
        src = s; bus_req = rq; bus_wen = we; bus_addr = {27'b0, r, 2'b0}; bus_dat_i = d;
        cand = -1;
        if (m_ins == 0)
            for (int i = 0; i < NR; i++)
                if (m_pend[i] && m_en[i]) begin
                    cand = i;
                    break;
                end
        n_pend = m_pend; n_en = m_en; n_edge = m_edge; n_ins = m_ins;
        if (rq && we && r == 0)
            for (int i = 0; i < NR; i++) if (d[i]) n_pend[i] = 0;
        if (rq && !we && r == 3 && cand >= 0) begin
            n_pend[cand] = 0;
            n_ins = cand + 1;
        end
        for (int i = 0; i < NR; i++)
            if (s[i] && (!m_edge[i] || !m_prev[i])) n_pend[i] = 1;
        if (rq && we && r == 1) n_en = d[NR-1:0];
        if (rq && we && r == 2) n_edge = d[NR-1:0];
        if (rq && we && r == 3 && m_ins != 0 && d == 32'(m_ins)) n_ins = 0;
        case (r)
            3'd0: rv = 32'(m_pend);
            3'd1: rv = 32'(m_en);
            3'd2: rv = 32'(m_edge);
            3'd3: rv = (cand >= 0) ? 32'(cand + 1) : 32'd0;
            3'd4: rv = 32'(m_ins);
            default: rv = 32'd0;
        endcase
        @(posedge clk);
        @(negedge clk);
        m_dat = (rq && !we) ? rv : 32'd0;
        m_irq = (cand >= 0);
        m_pend = n_pend; m_en = n_en; m_edge = n_edge; m_ins = n_ins; m_prev = s;
    endtask

    task automatic rd(input logic [7:0] s, input logic [2:0] r, input logic [31:0] exp, input string name);
        cyc(s, 1, 0, r, 0);
        chk(name, bus_dat_o, exp);
    endtask

    task automatic wr(input logic [7:0] s, input logic [2:0] r, input logic [31:0] d);
        cyc(s, 1, 1, r, d);
    endtask

    task automatic add(input logic [7:0] s, input bit rq, input bit we, input logic [2:0] r,
                       input logic [31:0] d, input bit ei, input logic [31:0] ed);
        vec_t v;
        v.s = s; v.rq = rq; v.we = we; v.r = r; v.d = d; v.ei = ei; v.ed = ed;
        vq.push_back(v);
    endtask

    initial begin
        // timer pulse, claim, in-service, no-candidate claim, bad complete, unmapped read
        add(8'h00, 1, 1, 1, 1, 0, 0);
        add(8'h01, 0, 0, 0, 0, 0, 0);
        add(8'h00, 0, 0, 0, 0, 1, 0);
        add(8'h00, 1, 0, 0, 0, 1, 1);
        add(8'h00, 1, 0, 3, 0, 1, 1);
        add(8'h00, 1, 0, 4, 0, 0, 1);
        add(8'h00, 1, 0, 0, 0, 0, 0);
        add(8'h00, 1, 0, 3, 0, 0, 0);
        add(8'h00, 1, 1, 3, 7, 0, 0);
        add(8'h00, 1, 0, 4, 0, 0, 1);
        add(8'h00, 1, 0, 5, 0, 0, 0);
        add(8'h00, 1, 1, 3, 1, 0, 0);
        add(8'h00, 1, 0, 4, 0, 0, 0);
        // disabled source stays pending, enabling it raises irq
        add(8'h00, 1, 1, 1, 0, 0, 0);
        add(8'h02, 0, 0, 0, 0, 0, 0);
        add(8'h00, 1, 0, 0, 0, 0, 2);
        add(8'h00, 1, 1, 1, 2, 0, 0);
        add(8'h00, 0, 0, 0, 0, 1, 0);
        add(8'h00, 1, 0, 3, 0, 1, 2);
        add(8'h00, 1, 1, 3, 2, 0, 0);
        add(8'h00, 0, 0, 0, 0, 0, 0);
        // edge and W1C on the same bit in the same cycle
        add(8'h00, 1, 1, 2, 5, 0, 0);
        add(8'h04, 1, 1, 0, 4, 0, 0);
        add(8'h00, 1, 0, 0, 0, 0, 4);
        add(8'h00, 1, 1, 0, 4, 0, 0);
        add(8'h00, 1, 0, 0, 0, 0, 0);

        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_irq", {31'b0, irq}, 0);
        chk("reset_dat", bus_dat_o, 0);
        chk("bus_ready", {31'b0, bus_ready}, 1);
        rst = 1'b1;
        rd(8'h00, 3'd2, 32'h1, "reset_edge");
        rd(8'h00, 3'd0, 32'h0, "reset_pending");

        foreach (vq[i]) begin
            cyc(vq[i].s, vq[i].rq, vq[i].we, vq[i].r, vq[i].d);
            chk($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vq[i].ei});
            chk($sformatf("vec%0d_dat", i), bus_dat_o, vq[i].ed);
        end

        // level src[3] and edge src[5] competing, non-nested claims
        wr(8'h00, 3'd2, 32'h21);
        wr(8'h00, 3'd1, 32'h28);
        cyc(8'h28, 0, 0, 0, 0);
        rd(8'h28, 3'd3, 32'd4, "claim_level3");
        rd(8'h28, 3'd3, 32'd0, "claim_nested");
        wr(8'h28, 3'd3, 32'd4);
        rd(8'h28, 3'd3, 32'd4, "claim_level3_again");
        wr(8'h20, 3'd3, 32'd4);
        rd(8'h20, 3'd3, 32'd4, "claim_level3_last");
        wr(8'h20, 3'd3, 32'd4);
        rd(8'h20, 3'd3, 32'd6, "claim_edge5");
        chk("irq_before_rst", {31'b0, irq}, 1);

        // asynchronous reset mid-service
        rst = 1'b0;
        #1;
        chk("async_irq", {31'b0, irq}, 0);
        chk("async_dat", bus_dat_o, 0);
        src = '0; bus_req = 0; bus_wen = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        rd(8'h00, 3'd0, 32'h0, "rst_pending");
        rd(8'h00, 3'd4, 32'h0, "rst_inserv");
        rd(8'h00, 3'd2, 32'h1, "rst_edge");
        rd(8'h00, 3'd1, 32'h0, "rst_enable");

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [7:0]  s;
            logic [2:0]  r;
            logic [31:0] d;
            bit rq, we;
            s = 8'($urandom) & 8'($urandom);
            r = 3'($urandom_range(0, 7));
            rq = $urandom_range(0, 3) != 0;
            we = $urandom_range(0, 2) == 0;
            d = $urandom;
            if (r == 3 && we && $urandom_range(0, 1) == 1) d = 32'(m_ins);
            cyc(s, rq, we, r, d);
            chk($sformatf("rnd%0d_irq", n), {31'b0, irq}, {31'b0, m_irq});
            chk($sformatf("rnd%0d_dat", n), bus_dat_o, m_dat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
